// File: rtl/busy_table_ckpt.sv
// PRF busy table with branch checkpoints: combinational source readiness with wakeup bypass, updates visible next cycle.
// No backpressure of its own; checkpoint requests are dropped while ckpt_full, so upstream stalls on it.
module busy_table_ckpt #(
  parameter int MACHINE_WIDTH = 4,
  parameter int ISSUE_WIDTH   = 7,
  parameter int PRF_DEPTH     = 64,
  parameter int PRF_WIDTH     = $clog2(PRF_DEPTH),
  parameter int NUM_CKPT      = 4,
  parameter int CKPT_W        = $clog2(NUM_CKPT)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pipe_flush,
  input  logic [MACHINE_WIDTH*PRF_WIDTH-1:0] free_prn,
  input  logic [MACHINE_WIDTH-1:0]           free_prn_valid,
  input  logic [MACHINE_WIDTH-1:0]           free_prn_ready,
  input  logic [ISSUE_WIDTH*PRF_WIDTH-1:0]   execute_prn,
  input  logic [ISSUE_WIDTH-1:0]             execute_valid,
  input  logic [MACHINE_WIDTH*PRF_WIDTH-1:0] pr_src1,
  input  logic [MACHINE_WIDTH*PRF_WIDTH-1:0] pr_src2,
  output logic [MACHINE_WIDTH-1:0]           pr_src1_data_ready,
  output logic [MACHINE_WIDTH-1:0]           pr_src2_data_ready,
  input  logic                               ckpt_req,
  output logic [CKPT_W-1:0]                  ckpt_id,
  output logic                               ckpt_full,
  input  logic                               ckpt_release,
  input  logic                               restore_valid,
  input  logic [CKPT_W-1:0]                  restore_id
);

  localparam logic [CKPT_W:0] FULL_CNT = (CKPT_W+1)'(NUM_CKPT);

  logic [PRF_DEPTH-1:0]     busy_q;
  logic [PRF_DEPTH-1:0]     busy_nxt;
  logic [PRF_DEPTH-1:0]     alloc_mask;
  logic [PRF_DEPTH-1:0]     wake_mask;
  logic [PRF_DEPTH-1:0]     snap_q [NUM_CKPT];
  logic [CKPT_W-1:0]        head_q;
  logic [CKPT_W-1:0]        tail_q;
  logic [CKPT_W:0]          count_q;
  logic [MACHINE_WIDTH-1:0] alloc_vld;
  logic                     take;
  logic                     rel;
  logic [CKPT_W-1:0]        restore_ofs;

  assign alloc_vld   = free_prn_valid & free_prn_ready;
  assign ckpt_full   = (count_q == FULL_CNT);
  assign ckpt_id     = tail_q;
  assign take        = ckpt_req && !ckpt_full && !restore_valid;
  assign rel         = ckpt_release && (count_q != '0) && !restore_valid;
  assign restore_ofs = restore_id - head_q;

  always_comb begin
    alloc_mask = '0;
    wake_mask  = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++)
      if (alloc_vld[i]) alloc_mask[free_prn[i*PRF_WIDTH +: PRF_WIDTH]] = 1'b1;
    for (int k = 0; k < ISSUE_WIDTH; k++)
      if (execute_valid[k]) wake_mask[execute_prn[k*PRF_WIDTH +: PRF_WIDTH]] = 1'b1;
    // wakeup wins over a same-cycle allocation of the same PRN
    busy_nxt = (busy_q | alloc_mask) & ~wake_mask;
  end

  // Readiness: table state with wakeup bypass, killed by an older slot allocating the same PRN.
  always_comb begin
    pr_src1_data_ready = '0;
    pr_src2_data_ready = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      logic [PRF_WIDTH-1:0] s1;
      logic [PRF_WIDTH-1:0] s2;
      logic                 r1;
      logic                 r2;
      s1 = pr_src1[i*PRF_WIDTH +: PRF_WIDTH];
      s2 = pr_src2[i*PRF_WIDTH +: PRF_WIDTH];
      r1 = !busy_q[s1] || wake_mask[s1];
      r2 = !busy_q[s2] || wake_mask[s2];
      for (int j = 0; j < i; j++) begin
        if (alloc_vld[j] && free_prn[j*PRF_WIDTH +: PRF_WIDTH] == s1) r1 = 1'b0;
        if (alloc_vld[j] && free_prn[j*PRF_WIDTH +: PRF_WIDTH] == s2) r2 = 1'b0;
      end
      pr_src1_data_ready[i] = r1;
      pr_src2_data_ready[i] = r2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int c = 0; c < NUM_CKPT; c++) snap_q[c] <= '0;
    end else if (pipe_flush) begin
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Snapshots track completions so a restore never resurrects a finished register.
      for (int c = 0; c < NUM_CKPT; c++) snap_q[c] <= snap_q[c] & ~wake_mask;
      if (restore_valid) begin
        busy_q  <= snap_q[restore_id] & ~wake_mask;
        tail_q  <= restore_id;
        count_q <= {1'b0, restore_ofs};
      end else begin
        busy_q <= busy_nxt;
        if (take) begin
          snap_q[tail_q] <= busy_nxt;
          tail_q         <= tail_q + 1'b1;
        end
        if (rel) head_q <= head_q + 1'b1;
        if (take && !rel)      count_q <= count_q + 1'b1;
        else if (rel && !take) count_q <= count_q - 1'b1;
      end
    end
  end

  a_alloc_wake_same_prn: assert property (@(posedge clk) disable iff (rst || pipe_flush)
    !(|(alloc_mask & wake_mask)));

  a_restore_live: assert property (@(posedge clk) disable iff (rst || pipe_flush)
    restore_valid |-> ({1'b0, restore_ofs} < count_q));

endmodule

// File: tb/tb_busy_table_ckpt.sv
// Scoreboard bench for busy_table_ckpt: expectations queued with stimulus, compared after outputs settle.
module tb_busy_table_ckpt;
  localparam int MW = 4;
  localparam int IW = 7;
  localparam int PW = 6;
  localparam int CW = 2;
  localparam int S1 = 0;
  localparam int S2 = 4;
  localparam int ID = 8;
  localparam int FULL = 9;

  logic clk = 1'b0;
  logic rst;
  logic pipe_flush;
  logic [MW*PW-1:0] free_prn;
  logic [MW-1:0]    free_prn_valid;
  logic [MW-1:0]    free_prn_ready;
  logic [IW*PW-1:0] execute_prn;
  logic [IW-1:0]    execute_valid;
  logic [MW*PW-1:0] pr_src1;
  logic [MW*PW-1:0] pr_src2;
  logic [MW-1:0]    pr_src1_data_ready;
  logic [MW-1:0]    pr_src2_data_ready;
  logic             ckpt_req;
  logic [CW-1:0]    ckpt_id;
  logic             ckpt_full;
  logic             ckpt_release;
  logic             restore_valid;
  logic [CW-1:0]    restore_id;

  busy_table_ckpt dut (
    .clk(clk), .rst(rst), .pipe_flush(pipe_flush),
    .free_prn(free_prn), .free_prn_valid(free_prn_valid), .free_prn_ready(free_prn_ready),
    .execute_prn(execute_prn), .execute_valid(execute_valid),
    .pr_src1(pr_src1), .pr_src2(pr_src2),
    .pr_src1_data_ready(pr_src1_data_ready), .pr_src2_data_ready(pr_src2_data_ready),
    .ckpt_req(ckpt_req), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .ckpt_release(ckpt_release), .restore_valid(restore_valid), .restore_id(restore_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    if (sel < S2)       return {31'b0, pr_src1_data_ready[sel]};
    else if (sel < ID)  return {31'b0, pr_src2_data_ready[sel-S2]};
    else if (sel == ID) return {30'b0, ckpt_id};
    else                return {31'b0, ckpt_full};
  endfunction

  task automatic push_exp(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic idle();
    pipe_flush = 0; free_prn = '0; free_prn_valid = '0; free_prn_ready = '0;
    execute_prn = '0; execute_valid = '0; pr_src1 = '0; pr_src2 = '0;
    ckpt_req = 0; ckpt_release = 0; restore_valid = 0; restore_id = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic alloc(input int s, input int p);
    free_prn[s*PW +: PW] = PW'(p);
    free_prn_valid[s] = 1'b1;
    free_prn_ready[s] = 1'b1;
  endtask

  task automatic wake(input int k, input int p);
    execute_prn[k*PW +: PW] = PW'(p);
    execute_valid[k] = 1'b1;
  endtask

  task automatic src1(input int s, input int p, input string tag, input int exp_rdy);
    pr_src1[s*PW +: PW] = PW'(p);
    push_exp(tag, S1 + s, exp_rdy);
  endtask

  task automatic src2(input int s, input int p, input string tag, input int exp_rdy);
    pr_src2[s*PW +: PW] = PW'(p);
    push_exp(tag, S2 + s, exp_rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    for (int i = 0; i < MW; i++) begin
      push_exp("rst_src1", S1 + i, 1);
      push_exp("rst_src2", S2 + i, 1);
    end
    push_exp("rst_id", ID, 0);
    push_exp("rst_full", FULL, 0);
    drain();

    // 1: group allocation then lookup
    tick();
    alloc(0, 5); alloc(1, 6); alloc(2, 7); alloc(3, 8);
    tick();
    src1(0, 5, "t1_busy5", 0);
    src1(1, 9, "t1_free9", 1);
    src2(2, 8, "t1_busy8", 0);
    src2(3, 6, "t1_busy6", 0);
    drain();

    // 2: intra-group dependency; valid-but-not-ready slot does not allocate
    tick();
    alloc(0, 12);
    free_prn[2*PW +: PW] = PW'(40);
    free_prn_valid[2] = 1'b1;
    src2(1, 12, "t2_kill_s1", 0);
    src2(0, 12, "t2_slot0", 1);
    src1(3, 12, "t2_kill_s3", 0);
    src2(3, 40, "t2_noaccept", 1);
    drain();
    tick();
    src2(0, 12, "t2_busy12", 0);
    src1(0, 40, "t2_free40", 1);
    drain();

    // 3: wakeup bypass
    tick();
    alloc(0, 20);
    tick();
    wake(6, 20);
    src1(2, 20, "t3_bypass", 1);
    src1(0, 20, "t3_bypass0", 1);
    src1(1, 5, "t3_other", 0);
    drain();
    tick();
    src1(2, 20, "t3_cleared", 1);
    drain();

    // 4: checkpoint, wakeup into snapshot, restore
    tick();
    alloc(0, 30);
    tick();
    ckpt_req = 1'b1;
    alloc(0, 33);
    push_exp("t4_id0", ID, 0);
    drain();
    tick();
    alloc(0, 31);
    push_exp("t4_notfull", FULL, 0);
    drain();
    tick();
    wake(0, 30);
    tick();
    restore_valid = 1'b1;
    restore_id = 2'd0;
    alloc(0, 34);
    tick();
    src1(0, 30, "t4_woken30", 1);
    src1(1, 31, "t4_after31", 1);
    src1(2, 33, "t4_snap33", 0);
    src1(3, 34, "t4_ignored34", 1);
    src2(0, 12, "t4_snap12", 0);
    src2(1, 5, "t4_snap5", 0);
    push_exp("t4_tail", ID, 0);
    push_exp("t4_full", FULL, 0);
    drain();

    // 5: fill, drop, release, wrap
    for (int k = 0; k < 4; k++) begin
      tick();
      ckpt_req = 1'b1;
      if (k == 1) alloc(0, 51);
      if (k == 2) alloc(0, 50);
      push_exp("t5_id", ID, k);
      drain();
    end
    tick();
    push_exp("t5_full", FULL, 1);
    push_exp("t5_drop_id", ID, 0);
    ckpt_req = 1'b1;
    drain();
    tick();
    push_exp("t5_still_full", FULL, 1);
    ckpt_release = 1'b1;
    drain();
    tick();
    push_exp("t5_rel_full", FULL, 0);
    push_exp("t5_wrap_id", ID, 0);
    ckpt_req = 1'b1;
    drain();
    tick();
    push_exp("t5_refull", FULL, 1);
    push_exp("t5_tail1", ID, 1);
    wake(0, 51);
    alloc(0, 52);
    drain();

    // 6: restore a middle checkpoint
    tick();
    restore_valid = 1'b1;
    restore_id = 2'd2;
    tick();
    push_exp("t6_tail", ID, 2);
    push_exp("t6_full", FULL, 0);
    src1(0, 50, "t6_snap50", 0);
    src1(1, 51, "t6_woken51", 1);
    src1(2, 52, "t6_post52", 1);
    src1(3, 12, "t6_snap12", 0);
    drain();
    tick();
    ckpt_req = 1'b1;
    ckpt_release = 1'b1;
    push_exp("t6_reqrel_id", ID, 2);
    drain();
    tick();
    push_exp("t6_reqrel_tail", ID, 3);
    push_exp("t6_reqrel_full", FULL, 0);
    drain();
    for (int k = 0; k < 3; k++) begin
      ckpt_req = 1'b1;
      push_exp("t6_fill_id", ID, (3 + k) % 4);
      drain();
      tick();
      push_exp("t6_fill_full", FULL, (k == 2) ? 1 : 0);
      drain();
    end

    // flush
    pipe_flush = 1'b1;
    tick();
    src1(0, 50, "fl_50", 1);
    src1(1, 12, "fl_12", 1);
    src2(2, 8, "fl_8", 1);
    push_exp("fl_id", ID, 0);
    push_exp("fl_full", FULL, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
